// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter block.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int OPS_CNT_W = 16;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted req at or after ptr wins.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] idx;

  // Walk the ring farthest-first so the requester closest to ptr is written last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (en && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One registered carry adder shared by NUM_REQ requesters; capture -> add -> respond.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [OPS_CNT_W-1:0]     ops_done,
  output logic                     busy
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH:0]         sum_q, sum_d;
  logic [OPS_CNT_W-1:0]   ops_done_q, ops_done_d;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .en       (state_q == ST_IDLE),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    ops_done_d = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          a_d      = req_a[int'(grant_id)*WIDTH +: WIDTH];
          b_d      = req_b[int'(grant_id)*WIDTH +: WIDTH];
          id_d     = grant_id;
          rr_ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          // Saturate rather than wrap so a stuck-high count is distinguishable.
          if (ops_done_q != '1) ops_done_d = ops_done_q + OPS_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q[WIDTH-1:0];
  assign rsp_carry = sum_q[WIDTH];
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, corner sequences, random vs. reference model.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic [15:0]    ops_done;
  logic           busy;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .ops_done  (ops_done),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           exp_id;
    logic [W-1:0] exp_sum;
    logic         exp_c;
    int           stall;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ops;
  int   ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_ops = 0; ptr = 0;
  endtask

  // One full transaction; called at posedge+1 with the DUT idle.
  task automatic txn(input logic [N-1:0] mask, input int eid, input logic [W-1:0] esum,
                     input logic ec, input int stall);
    req_valid = mask;
    rsp_ready = (stall == 0);
    #1 chk("grant", 32'(req_ready), 32'(1) << eid);
    @(posedge clock); #1;
    chk("busy_add", 32'(busy), 1);
    chk("ready_add", 32'(req_ready), 0);
    chk("valid_add", 32'(rsp_valid), 0);
    @(posedge clock); #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(eid));
    chk("rsp_sum", 32'(rsp_sum), 32'(esum));
    chk("rsp_carry", 32'(rsp_carry), 32'(ec));
    chk("ready_resp", 32'(req_ready), 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_sum", {rsp_carry, rsp_id, rsp_sum}, {ec, 2'(eid), esum});
      chk("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    if (exp_ops != 16'hFFFF) exp_ops++;
    ptr = (eid + 1) % N;
    chk("rsp_done", 32'(rsp_valid), 0);
    chk("ops_done", 32'(ops_done), 32'(exp_ops));
  endtask

  task automatic model_txn(input logic [N-1:0] mask, input int stall);
    int id, s;
    id = rr_pick(mask, ptr);
    s  = int'(req_a[id*W +: W]) + int'(req_b[id*W +: W]);
    txn(mask, id, W'(s), s > 255, stall);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0100, 8'h12, 8'h34, 2, 8'h46, 1'b0, 0};
    vecs[1] = '{4'b0001, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 0};
    vecs[2] = '{4'b0001, 8'h80, 8'h80, 0, 8'h00, 1'b1, 0};
    vecs[3] = '{4'b0001, 8'hFF, 8'hFF, 0, 8'hFE, 1'b1, 0};
    vecs[4] = '{4'b1010, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 10};
    vecs[5] = '{4'b1010, 8'hF0, 8'h20, 3, 8'h10, 1'b1, 0};
    req_a = '0; req_b = '0;

    do_reset();
    chk("rst_state", {27'd0, req_ready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_carry, rsp_id, rsp_sum}, 0);
    chk("rst_ops", 32'(ops_done), 0);
    chk("rst_busy", 32'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      req_a = {N{vecs[i].a}};
      req_b = {N{vecs[i].b}};
      txn(vecs[i].mask, vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_c, vecs[i].stall);
    end

    // Fairness: all requesters always valid, grants rotate 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(8'h60 * i);
      req_b[i*W +: W] = 8'hA0;
    end
    for (int g = 0; g < 6; g++) begin
      int s;
      s = int'(req_a[(g % N)*W +: W]) + 8'hA0;
      txn(4'b1111, g % N, W'(s), s > 255, 0);
    end

    // Reset while in ADD discards the op and restarts arbitration at id 0.
    req_valid = '0;
    do_reset();
    req_valid = 4'b1110;
    @(posedge clock); #1;
    chk("mid_busy", 32'(busy), 1);
    reset_n = 1'b0; req_valid = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_ops = 0; ptr = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("mid_no_rsp", 32'(rsp_valid), 0);
    end
    model_txn(4'b1111, 0);

    // Reset and handshake on the same edge: nothing captured.
    reset_n = 1'b0; req_valid = 4'b1111;
    @(posedge clock); #1;
    reset_n = 1'b1; req_valid = '0;
    exp_ops = 0; ptr = 0;
    chk("rst_hs_busy", 32'(busy), 0);
    chk("rst_hs_ops", 32'(ops_done), 0);
    @(posedge clock); #1;
    chk("rst_hs_norsp", 32'(rsp_valid), 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] m;
      req_a = $urandom();
      req_b = $urandom();
      m = N'($urandom_range(0, 15));
      if (m == '0) begin
        req_valid = '0;
        #1 chk("idle_ready", 32'(req_ready), 0);
        @(posedge clock); #1;
        chk("idle_busy", 32'(busy), 0);
      end else begin
        model_txn(m, $urandom_range(0, 2));
      end
    end

    // Counter saturation: preload near the top, then run past it.
    req_valid = '0;
    force dut.ops_done_q = 16'hFFFD;
    #1 release dut.ops_done_q;
    exp_ops = 16'hFFFD;
    for (int t = 0; t < 4; t++) begin
      req_a = $urandom();
      req_b = $urandom();
      model_txn(4'b0001, 0);
    end
    chk("sat_hold", 32'(ops_done), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
